// File: rtl/kernel_reader.sv
// Read side of the three-bank row-interleaved pixel buffer: walks one frame in raster order
// and emits one edge-clamped 3x3 RGB kernel per pixel.
module kernel_reader #(
    parameter int unsigned X          = 320,
    parameter int unsigned THIRD_OF_Y = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       frame_sel,
    output logic [16:0]      reada,
    output logic [16:0]      readb,
    output logic [16:0]      readc,
    input  logic [23:0]      dataa,
    input  logic [23:0]      datab,
    input  logic [23:0]      datac,
    output logic [8:0][23:0] kernel_out,
    output logic             kernel_valid,
    output logic [8:0]       center_x,
    output logic [7:0]       center_y,
    output logic             busy,
    output logic             done
);

    localparam int unsigned Y           = 3 * THIRD_OF_Y;
    localparam logic [16:0] XW          = 17'(X);
    localparam logic [16:0] FRAME_WORDS = 17'(X * THIRD_OF_Y);
    localparam logic [8:0]  X_LAST      = 9'(X - 1);
    localparam logic [7:0]  Y_LAST      = 8'(Y - 1);

    typedef enum logic [1:0] {StIdle, StRow, StGap, StDrain} state_t;

    state_t      state_q, state_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [1:0]  m_q, m_d;               // y % 3
    logic [16:0] line_off_q, line_off_d; // (y / 3) * X
    logic [1:0]  frame_q, frame_d;
    logic        done_q, done_d;
    logic [16:0] reada_q, readb_q, readc_q;
    logic [16:0] addr_a, addr_b, addr_c;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        m_d        = m_q;
        line_off_d = line_off_q;
        frame_d    = frame_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRow;
                    x_d        = '0;
                    y_d        = '0;
                    m_d        = '0;
                    line_off_d = '0;
                    frame_d    = (frame_sel == 2'd3) ? 2'd0 : frame_sel;
                end
            end
            StRow: begin
                if (x_q == X_LAST) state_d = StGap;
                else               x_d = x_q + 9'd1;
            end
            StGap: begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    state_d = StDrain;
                end else begin
                    state_d = StRow;
                    y_d     = y_q + 8'd1;
                    if (m_q == 2'd2) begin
                        m_d        = 2'd0;
                        line_off_d = line_off_q + XW;
                    end else begin
                        m_d = m_q + 2'd1;
                    end
                end
            end
            StDrain: begin
                // Two cycles cover the read latency and the right-edge kernel.
                if (x_q == 9'd1) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    x_d = x_q + 9'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Out-of-frame neighbour rows keep the centre chunk so addresses never leave the frame.
    logic [16:0] fbase, off_top, off_bot, off_a, off_b, off_c, col;

    always_comb begin
        unique case (frame_d)
            2'd1:    fbase = FRAME_WORDS;
            2'd2:    fbase = FRAME_WORDS << 1;
            default: fbase = '0;
        endcase
        off_top = (m_d == 2'd0 && y_d != 8'd0) ? line_off_d - XW : line_off_d;
        off_bot = (m_d == 2'd2 && y_d != Y_LAST) ? line_off_d + XW : line_off_d;
        unique case (m_d)
            2'd0: begin off_a = line_off_d; off_b = off_bot;    off_c = off_top;    end
            2'd1: begin off_a = off_top;    off_b = line_off_d; off_c = off_bot;    end
            default: begin off_a = off_bot; off_b = off_top;    off_c = line_off_d; end
        endcase
        col    = {8'b0, x_d};
        addr_a = fbase + off_a + col;
        addr_b = fbase + off_b + col;
        addr_c = fbase + off_c + col;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            m_q        <= '0;
            line_off_q <= '0;
            frame_q    <= '0;
            done_q     <= 1'b0;
            reada_q    <= '0;
            readb_q    <= '0;
            readc_q    <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            m_q        <= m_d;
            line_off_q <= line_off_d;
            frame_q    <= frame_d;
            done_q     <= done_d;
            if (state_d == StRow) begin
                reada_q <= addr_a;
                readb_q <= addr_b;
                readc_q <= addr_c;
            end
        end
    end

    // Returned-data stage: tags for the column whose data is on the bus this cycle.
    logic        dv_q, tail_q;
    logic [8:0]  dx_q;
    logic [7:0]  dy_q, row_y_q;
    logic [1:0]  dm_q;
    logic [2:0][23:0] new_col, col_l_q, col_c_q; // [0]=top [1]=mid [2]=bot
    logic [23:0] d_mid, d_up, d_dn;

    always_comb begin
        unique case (dm_q)
            2'd0: begin d_mid = dataa; d_up = datac; d_dn = datab; end
            2'd1: begin d_mid = datab; d_up = dataa; d_dn = datac; end
            default: begin d_mid = datac; d_up = datab; d_dn = dataa; end
        endcase
        new_col[1] = d_mid;
        new_col[0] = (dy_q == 8'd0) ? d_mid : d_up;
        new_col[2] = (dy_q == Y_LAST) ? d_mid : d_dn;
    end

    logic [2:0][23:0] win_l, win_c, win_r;
    logic [8:0][23:0] kern;
    logic             kv;
    logic [8:0]       kx;
    logic [7:0]       ky;

    always_comb begin
        win_l = col_l_q;
        win_c = col_c_q;
        win_r = new_col;
        kv    = 1'b0;
        kx    = dx_q - 9'd1;
        ky    = dy_q;
        if (dv_q && dx_q != 9'd0) begin
            kv = 1'b1;
            if (dx_q == 9'd1) win_l = col_c_q;
        end else if (tail_q) begin
            kv    = 1'b1;
            win_r = col_c_q;
            kx    = X_LAST;
            ky    = row_y_q;
        end
        for (int r = 0; r < 3; r++) begin
            kern[3*r]     = win_l[r];
            kern[3*r + 1] = win_c[r];
            kern[3*r + 2] = win_r[r];
        end
    end

    logic [8:0][23:0] kernel_q;
    logic             kvalid_q;
    logic [8:0]       kx_q;
    logic [7:0]       ky_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv_q     <= 1'b0;
            tail_q   <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
            dm_q     <= '0;
            row_y_q  <= '0;
            col_l_q  <= '0;
            col_c_q  <= '0;
            kernel_q <= '0;
            kvalid_q <= 1'b0;
            kx_q     <= '0;
            ky_q     <= '0;
        end else begin
            dv_q   <= (state_q == StRow);
            dx_q   <= x_q;
            dy_q   <= y_q;
            dm_q   <= m_q;
            tail_q <= dv_q && (dx_q == X_LAST);
            if (dv_q) begin
                col_l_q <= col_c_q;
                col_c_q <= new_col;
                row_y_q <= dy_q;
            end
            kvalid_q <= kv;
            if (kv) begin
                kernel_q <= kern;
                kx_q     <= kx;
                ky_q     <= ky;
            end
        end
    end

    assign reada        = reada_q;
    assign readb        = readb_q;
    assign readc        = readc_q;
    assign kernel_out   = kernel_q;
    assign kernel_valid = kvalid_q;
    assign center_x     = kx_q;
    assign center_y     = ky_q;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;

endmodule

// File: tb/tb_kernel_reader.sv
// Directed bench for kernel_reader: bank model returns pixel {5'b0, frame, y[7:0], x[8:0]}.
module tb_kernel_reader;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       frame_sel;
    logic [16:0]      reada, readb, readc;
    logic [23:0]      dataa, datab, datac;
    logic [8:0][23:0] kernel_out;
    logic             kernel_valid;
    logic [8:0]       center_x;
    logic [7:0]       center_y;
    logic             busy, done;

    kernel_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .frame_sel    (frame_sel),
        .reada        (reada),
        .readb        (readb),
        .readc        (readc),
        .dataa        (dataa),
        .datab        (datab),
        .datac        (datac),
        .kernel_out   (kernel_out),
        .kernel_valid (kernel_valid),
        .center_x     (center_x),
        .center_y     (center_y),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pix(input int f, input int x, input int y);
        return 24'((f << 17) | (y << 9) | x);
    endfunction

    function automatic logic [23:0] bank_word(input int bank, input logic [16:0] a);
        int ai, rem;
        ai  = int'(a);
        rem = ai % 25600;
        return pix(ai / 25600, rem % 320, 3 * (rem / 320) + bank);
    endfunction

    always @(posedge clk) begin
        dataa <= bank_word(0, reada);
        datab <= bank_word(1, readb);
        datac <= bank_word(2, readc);
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-run observations
    int s_cyc, pulse_at, exp_frame;
    logic [1:0] pulse_sel;
    int nk, kerr, ex, ey, bad_x, bad_y;
    int first_valid, line1_cyc, line2_cyc, last_valid, done_cyc, done_cnt, done_busy;
    int busy_cnt, busy_s0, busy_s1, max_c, max_all;
    logic [16:0] ra_s1, a3a, a3b, a3c;
    logic [8:0][23:0] k00, k51, k52, k53, kint, klast;

    task automatic clear_stats(input int s, input logic [1:0] sel, input int ef);
        s_cyc = s; pulse_at = s; pulse_sel = sel; exp_frame = ef;
        nk = 0; kerr = 0; ex = 0; ey = 0; bad_x = -1; bad_y = -1;
        first_valid = -1; line1_cyc = -1; line2_cyc = -1; last_valid = -1;
        done_cyc = -1; done_cnt = 0; done_busy = -1; busy_cnt = 0;
        busy_s0 = -1; busy_s1 = -1; max_c = 0; max_all = 0;
        ra_s1 = '1; a3a = '1; a3b = '1; a3c = '1;
        k00 = '1; k51 = '1; k52 = '1; k53 = '1; kint = '1; klast = '1;
    endtask

    task automatic watch(input int until_cyc, input bit stop_on_done);
        int err, px, py;
        for (int i = 0; i < 90000; i++) begin
            @(negedge clk);
            if (cyc == s_cyc) busy_s0 = int'(busy);
            if (cyc == s_cyc + 1) begin ra_s1 = reada; busy_s1 = int'(busy); end
            if (cyc == s_cyc + 1 + 3 * 321) begin a3a = reada; a3b = readb; a3c = readc; end
            if (busy) begin
                busy_cnt++;
                if (int'(readc) > max_c) max_c = int'(readc);
                if (int'(reada) > max_all) max_all = int'(reada);
                if (int'(readb) > max_all) max_all = int'(readb);
                if (int'(readc) > max_all) max_all = int'(readc);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; done_busy = int'(busy); end
            end
            if (kernel_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (ey == 1 && ex == 0) line1_cyc = cyc;
                if (ey == 2 && ex == 0) line2_cyc = cyc;
                last_valid = cyc;
                nk++;
                err = (int'(center_x) != ex || int'(center_y) != ey) ? 1 : 0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        px = ex + c - 1; py = ey + r - 1;
                        if (px < 0) px = 0;
                        if (px > 319) px = 319;
                        if (py < 0) py = 0;
                        if (py > 239) py = 239;
                        if (kernel_out[3*r + c] !== pix(exp_frame, px, py)) err = 1;
                    end
                end
                if (err != 0) begin
                    kerr++;
                    if (bad_x < 0) begin bad_x = ex; bad_y = ey; end
                end
                if (ex == 0 && ey == 0) k00 = kernel_out;
                if (ex == 5 && ey == 1) k51 = kernel_out;
                if (ex == 5 && ey == 2) k52 = kernel_out;
                if (ex == 5 && ey == 3) k53 = kernel_out;
                if (ex == 100 && ey == 50) kint = kernel_out;
                if (ex == 319 && ey == 239) klast = kernel_out;
                ex++;
                if (ex == 320) begin ex = 0; ey++; end
            end
            if (cyc == pulse_at) begin
                start = 1'b1;
                frame_sel = pulse_sel;
            end else begin
                start = 1'b0;
                if (cyc == pulse_at + 1) frame_sel = 2'd1;
            end
            if (cyc >= until_cyc) break;
            if (stop_on_done && done_cnt > 0 && cyc >= done_cyc + 2) break;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_reada"}, 64'(reada), 64'd0);
        check({tag, "_readb"}, 64'(readb), 64'd0);
        check({tag, "_readc"}, 64'(readc), 64'd0);
        check({tag, "_kernel"}, 64'(|kernel_out), 64'd0);
        check({tag, "_kvalid"}, 64'(kernel_valid), 64'd0);
        check({tag, "_cxy"}, 64'({center_x, center_y}), 64'd0);
        check({tag, "_busy_done"}, 64'({busy, done}), 64'd0);
    endtask

    int s;

    initial begin
        reset = 1'b1; start = 1'b0; frame_sel = 2'd0;
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Run 1: frame 0 from cycle 10, ignored second start at 500, async reset at 2000.
        clear_stats(10, 2'd0, 0);
        watch(499, 1'b0);
        pulse_at = 500; pulse_sel = 2'd2;
        watch(2000, 1'b0);
        check("r1_valid_before_reset", 64'(kernel_valid), 64'd1);
        #2 reset = 1'b0;
        #1 check_zero_outputs("midreset");
        check("r1_busy_s", 64'(busy_s0), 64'd0);
        check("r1_busy_s1", 64'(busy_s1), 64'd1);
        check("r1_reada_s1", 64'(ra_s1), 64'd0);
        check("r1_first_valid", 64'(first_valid), 64'd14);
        check("r1_line1", 64'(line1_cyc), 64'd335);
        check("r1_line2_after_ignored_start", 64'(line2_cyc), 64'd656);
        check("r1_y3_reada", 64'(a3a), 64'd320);
        check("r1_y3_readb", 64'(a3b), 64'd320);
        check("r1_y3_readc", 64'(a3c), 64'd0);
        check("r1_kernels", 64'(nk), 64'd1981);
        check("r1_kernel_errors", 64'(kerr), 64'd0);
        check("r1_first_bad_xy", 64'({bad_x, bad_y}), {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        check("r1_no_done", 64'(done_cnt), 64'd0);
        check("c00_k0", 64'(k00[0]), 64'h000000);
        check("c00_k2", 64'(k00[2]), 64'h000001);
        check("c00_k4", 64'(k00[4]), 64'h000000);
        check("c00_k6", 64'(k00[6]), 64'h000200);
        check("c00_k8", 64'(k00[8]), 64'h000201);
        check("y1_rows", 64'({k51[1], k51[4], k51[7]}), {16'd0, 24'h000005, 24'h000205, 24'h000405});
        check("y2_rows", 64'({k52[1], k52[4], k52[7]}), {16'd0, 24'h000205, 24'h000405, 24'h000605});
        check("y3_rows", 64'({k53[1], k53[4], k53[7]}), {16'd0, 24'h000405, 24'h000605, 24'h000805});
        repeat (3) @(negedge clk);
        check("held_reset_busy", 64'({busy, done, kernel_valid}), 64'd0);
        reset = 1'b1;

        // Run 2: frame_sel=3 behaves as frame 0.
        s = cyc + 5;
        clear_stats(s, 2'd3, 0);
        watch(s + 700, 1'b0);
        check("r2_reada_s1", 64'(ra_s1), 64'd0);
        check("r2_first_valid", 64'(first_valid - s), 64'd4);
        check("r2_kernels", 64'(nk), 64'd695);
        check("r2_kernel_errors", 64'(kerr), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Run 3: full frame 2, frame_sel changed after acceptance.
        s = cyc + 5;
        clear_stats(s, 2'd2, 2);
        watch(s + 78000, 1'b1);
        check("r3_reada_s1", 64'(ra_s1), 64'd51200);
        check("r3_kernels", 64'(nk), 64'd76800);
        check("r3_kernel_errors", 64'(kerr), 64'd0);
        check("r3_first_bad_xy", 64'({bad_x, bad_y}), {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        check("r3_first_valid", 64'(first_valid - s), 64'd4);
        check("r3_last_valid", 64'(last_valid - s), 64'd77042);
        check("r3_done_cycle", 64'(done_cyc - s), 64'd77043);
        check("r3_done_pulses", 64'(done_cnt), 64'd1);
        check("r3_busy_at_done", 64'(done_busy), 64'd0);
        check("r3_busy_cycles", 64'(busy_cnt), 64'd77042);
        check("r3_max_readc", 64'(max_c), 64'd76799);
        check("r3_max_addr", 64'(max_all), 64'd76799);
        check("int_k0", 64'(kint[0]), 64'h046263);
        check("int_k8", 64'(kint[8]), 64'h046665);
        check("last_k8", 64'(klast[8]), 64'h05DF3F);
        check("last_k4", 64'(klast[4]), 64'h05DF3F);
        check("last_k2", 64'(klast[2]), 64'h05DD3F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
